// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader and the opcode decoder.
// Contents: opcode constants, instruction format enum, field bit positions
// and an opcode-to-format classifier.
package instr_encoder_loader_pkg;

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_JI,
      FMT_JII,
      FMT_ILL
   } fmt_e;

   // LSB position of each field in the 32-bit instruction word
   localparam int unsigned OPC_LSB   = 27;
   localparam int unsigned RD_LSB    = 22;
   localparam int unsigned RS_LSB    = 17;
   localparam int unsigned RT_LSB    = 12;
   localparam int unsigned SHAMT_LSB = 7;
   localparam int unsigned ALUOP_LSB = 2;

   function automatic fmt_e classify(input logic [4:0] op);
      fmt_e f;
      case (op)
         OP_R:                                  f = FMT_R;
         OP_BNE, OP_ADDI, OP_BLT, OP_SW, OP_LW: f = FMT_I;
         OP_J, OP_JAL, OP_SETX, OP_BEX:         f = FMT_JI;
         OP_JR:                                 f = FMT_JII;
         default:                               f = FMT_ILL;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Synchronous FIFO holding encoded instruction words.
// Ports: clock/reset_n, i_push/i_data write side, i_pop read side,
// o_data = head entry, o_full/o_empty status. Push when full and pop when
// empty are ignored. Reset flushes the pointers; storage is not cleared.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Extra pointer MSB distinguishes full from empty when indices match
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder and imem loader.
// Accepts instruction field bundles (in_valid/in_ready), classifies the
// opcode, packs a 32-bit word, buffers it and writes it to imem at
// sequential addresses from base_addr.
// Ports: clock, reset_n; start/base_addr session control; field inputs
// opcode/rd/rs/rt/shamt/aluop/imm/target/last; imem_we/addr/data with
// imem_ready handshake; status busy, done, err, err_count.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned ERR_W      = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        shamt,
   input  logic [4:0]        aluop,
   input  logic [16:0]       imm,
   input  logic [26:0]       target,
   input  logic              last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_data,
   input  logic              imem_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ERR_W-1:0]  err_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_err;
   logic [ERR_W-1:0]  r_err_cnt;
   fmt_e              w_fmt;
   logic [31:0]       w_word;
   logic [31:0]       w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_start;

   assign w_fmt    = classify(opcode);
   assign in_ready = (r_state == ST_LOAD) && !w_full;
   assign w_accept = in_valid && in_ready;
   assign w_push   = w_accept && (w_fmt != FMT_ILL);
   assign w_pop    = imem_we && imem_ready;
   assign w_start  = (r_state == ST_IDLE) && start;

   always_comb begin
      w_word = '0;
      w_word[OPC_LSB +: 5] = opcode;
      case (w_fmt)
         FMT_R: begin
            w_word[RD_LSB +: 5]    = rd;
            w_word[RS_LSB +: 5]    = rs;
            w_word[RT_LSB +: 5]    = rt;
            w_word[SHAMT_LSB +: 5] = shamt;
            w_word[ALUOP_LSB +: 5] = aluop;
         end
         FMT_I: begin
            w_word[RD_LSB +: 5] = rd;
            w_word[RS_LSB +: 5] = rs;
            w_word[16:0]        = imm;
         end
         FMT_JI:  w_word[26:0] = target;
         FMT_JII: w_word[RD_LSB +: 5] = rd;
         default: w_word = '0;
      endcase
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
         ST_LOAD:  if (w_accept && last) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_empty) w_state_nxt = ST_DONE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_addr    <= base_addr;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
         end else begin
            // Natural wrap modulo 2^ADDR_W
            if (w_pop) r_addr <= r_addr + ADDR_W'(1);
            if (w_accept && (w_fmt == FMT_ILL)) begin
               r_err <= 1'b1;
               if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
         end
      end
   end

   assign imem_we   = !w_empty;
   assign imem_addr = r_addr;
   // Head storage is not reset, so mask it while nothing is pending
   assign imem_data = w_empty ? 32'h0 : w_head;
   assign busy      = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
   assign done      = (r_state == ST_DONE);
   assign err       = r_err;
   assign err_count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  opcode = '0, rd = '0, rs = '0, rt = '0, shamt = '0, aluop = '0;
   logic [16:0] imm = '0;
   logic [26:0] target = '0;
   logic        last = 1'b0;
   logic        imem_we;
   logic [11:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_ready = 1'b0;
   logic        busy, done, err;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fails  = 0;
   logic        hold = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] wr_data[$];
   logic [11:0] wr_addr[$];
   logic [11:0] exp_addr = '0;
   logic        exp_err = 1'b0;
   int          exp_cnt = 0;
   int          done_cnt = 0;
   int          done_base = 0;

   always #5 clock = ~clock;

   instr_encoder_loader #(
      .ADDR_W     (12),
      .FIFO_DEPTH (2),
      .ERR_W      (8)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .rd         (rd),
      .rs         (rs),
      .rt         (rt),
      .shamt      (shamt),
      .aluop      (aluop),
      .imm        (imm),
      .target     (target),
      .last       (last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .imem_ready (imem_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_count  (err_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoding straight from the format table
   function automatic bit ref_legal(input logic [4:0] op);
      return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22};
   endfunction

   function automatic logic [31:0] ref_word(input logic [4:0] op, r_d, r_s, r_t, sh, alu,
                                            input logic [16:0] im, input logic [26:0] tg);
      if (op == 5'd0)                             return {op, r_d, r_s, r_t, sh, alu, 2'b00};
      if (op inside {5'd2, 5'd5, 5'd6, 5'd7, 5'd8}) return {op, r_d, r_s, im};
      if (op inside {5'd1, 5'd3, 5'd21, 5'd22})     return {op, tg};
      return {op, r_d, 22'h0};
   endfunction

   // imem_ready: random unless held low by the stimulus
   initial forever begin
      @(posedge clock);
      #2;
      imem_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Write monitor / scoreboard; the transfer happens at the following edge
   initial forever begin
      @(negedge clock);
      if (done) done_cnt++;
      if (reset_n && imem_we && imem_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            check("wr_addr", imem_addr, exp_addr);
            check("wr_data", imem_data, exp_q.pop_front());
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_data);
            exp_addr = exp_addr + 12'd1;
         end
      end
   end

   task automatic do_start(input logic [11:0] base);
      int n = 0;
      while ((busy || done) && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("idle_timeout", n < 200, 1);
      @(posedge clock);
      #1;
      start = 1'b1;
      base_addr = base;
      @(posedge clock);
      #1;
      start = 1'b0;
      base_addr = $urandom_range(0, 4095);
      exp_addr = base;
      exp_err = 1'b0;
      exp_cnt = 0;
      done_base = done_cnt;
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic send(input logic [4:0] op, r_d, r_s, r_t, sh, alu,
                       input logic [16:0] im, input logic [26:0] tg, input logic lst);
      int n = 0;
      opcode = op; rd = r_d; rs = r_s; rt = r_t; shamt = sh; aluop = alu;
      imm = im; target = tg; last = lst;
      in_valid = 1'b1;
      forever begin
         @(negedge clock);
         #1;
         if (in_ready) break;
         n++;
         if (n >= 200) break;
      end
      check("accept_timeout", n < 200, 1);
      if (n < 200) begin
         if (ref_legal(op)) begin
            exp_q.push_back(ref_word(op, r_d, r_s, r_t, sh, alu, im, tg));
         end else begin
            exp_err = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
         end
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      if (lst) check("in_ready_after_last", in_ready, 0);
   endtask

   task automatic send_rand(input logic [4:0] op, input logic lst);
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           17'($urandom), 27'($urandom), lst);
   endtask

   task automatic end_session();
      int n = 0;
      while (!((done_cnt - done_base) > 0 && !busy && !done) && n < 500) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("session_timeout", n < 500, 1);
      check("done_pulses", done_cnt - done_base, 1);
      check("busy_end", busy, 0);
      check("pending_words", exp_q.size(), 0);
      check("err", err, exp_err);
      check("err_count", err_count, exp_cnt);
   endtask

   initial begin
      #1;
      check("rst_we", imem_we, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_data", imem_data, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_err_count", err_count, 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      check("idle_in_ready", in_ready, 0);

      // Directed program: R, addi with junk, j, jr
      do_start(12'h010);
      check("busy_load", busy, 1);
      send(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'h1ffff, 27'h7ffffff, 1'b0);
      send(5'd5, 5'd1, 5'd2, 5'd31, 5'd31, 5'd31, 17'd5, 27'h7ffffff, 1'b0);
      send(5'd1, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1ffff, 27'd100, 1'b0);
      send(5'd4, 5'd31, 5'd7, 5'd7, 5'd7, 5'd7, 17'h1ffff, 27'h7ffffff, 1'b1);
      end_session();
      check("dir_nwr", wr_data.size(), 4);
      if (wr_data.size() == 4) begin
         check("dir_d0", wr_data[0], 32'h00C22000);
         check("dir_a0", wr_addr[0], 12'h010);
         check("dir_d1", wr_data[1], 32'h28440005);
         check("dir_d2", wr_data[2], 32'h08000064);
         check("dir_d3", wr_data[3], 32'h27C00000);
         check("dir_a3", wr_addr[3], 12'h013);
      end

      // Illegal opcode between two legal bundles
      do_start(12'h020);
      send_rand(5'd5, 1'b0);
      send_rand(5'd31, 1'b0);
      send_rand(5'd1, 1'b1);
      end_session();
      check("ill_nwr", wr_data.size(), 2);
      if (wr_data.size() == 2) check("ill_a1", wr_addr[1], 12'h021);

      // Stall: 3 bundles offered while imem_ready is held low
      do_start(12'h100);
      hold = 1'b1;
      send(5'd0, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 17'h1ffff, 27'h7ffffff, 1'b0);
      send(5'd7, 5'd4, 5'd3, 5'd1, 5'd1, 5'd1, 17'h00abc, 27'h0, 1'b0);
      opcode = 5'd3; target = 27'h1234567; last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         check("stall_in_ready", in_ready, 0);
         check("stall_we", imem_we, 1);
         check("stall_addr", imem_addr, 12'h100);
         check("stall_data", imem_data, ref_word(5'd0, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 0, 0));
      end
      hold = 1'b0;
      send(5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h0, 27'h1234567, 1'b1);
      end_session();
      check("stall_nwr", wr_data.size(), 3);

      // Address wrap
      do_start(12'hFFF);
      send_rand(5'd2, 1'b0);
      send_rand(5'd22, 1'b1);
      end_session();
      check("wrap_nwr", wr_data.size(), 2);
      if (wr_data.size() == 2) begin
         check("wrap_a0", wr_addr[0], 12'hFFF);
         check("wrap_a1", wr_addr[1], 12'h000);
      end

      // Illegal opcode ending the session, and counter saturation
      do_start(12'h300);
      for (int i = 0; i < 258; i++) send_rand(5'd31 - 5'(i % 8), i == 257);
      end_session();

      // Randomised sessions
      for (int s = 0; s < 6; s++) begin
         do_start(12'($urandom));
         for (int i = 0; i < 10; i++) send_rand(5'($urandom), i == 9);
         end_session();
      end

      // start outside IDLE must not reload the address
      do_start(12'h400);
      send_rand(5'd0, 1'b0);
      start = 1'b1; base_addr = 12'h700;
      send_rand(5'd8, 1'b1);
      start = 1'b0;
      end_session();
      if (wr_addr.size() == 2) check("restart_ignored", wr_addr[1], 12'h401);
      else check("restart_nwr", wr_addr.size(), 2);

      // Reset mid-session discards buffered words
      do_start(12'h200);
      hold = 1'b1;
      send_rand(5'd0, 1'b0);
      send_rand(5'd5, 1'b0);
      reset_n = 1'b0;
      #1;
      check("mrst_we", imem_we, 0);
      check("mrst_addr", imem_addr, 0);
      check("mrst_data", imem_data, 0);
      check("mrst_busy", busy, 0);
      check("mrst_in_ready", in_ready, 0);
      check("mrst_err_count", err_count, 0);
      exp_q.delete();
      hold = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
      check("mrst_we_after", imem_we, 0);
      check("mrst_busy_after", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder counterpart of the processor's opcode decoder. It accepts instruction fields over a valid/ready interface, classifies the 5-bit opcode into R / I / JI / JII format, and packs the fields into a 32-bit instruction word. It buffers encoded words in a small FIFO and streams them into instruction memory at sequential addresses starting from a programmable base. It sits between the boot/test program source and the imem write port.

Parameters:
ADDR_W, 12, imem address width
FIFO_DEPTH, 2, encoded-word buffer depth (power of 2, >=2)
ERR_W, 8, illegal-opcode counter width

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  pulse; begins a load session (honoured only in IDLE)
base_addr  in  ADDR_W  first imem address, sampled on accepted start
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
opcode  in  5  instruction opcode
rd, rs, rt, shamt, aluop  in  5 each  register/shift/ALU fields
imm  in  17  I-type immediate
target  in  27  JI-type target
last  in  1  qualifies final bundle of the session
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  write address
imem_data  out  32  encoded word
imem_ready  in  1  memory accepts the write this cycle
busy  out  1  high in LOAD or DRAIN
done  out  1  one-cycle pulse at session end
err  out  1  sticky; an illegal opcode was seen this session
err_count  out  ERR_W  saturating count of illegal opcodes this session

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, FIFO flushed, address=0, in_ready=0, imem_we=0, imem_addr=0, imem_data=0, busy=0, done=0, err=0, err_count=0. A reset mid-session discards all buffered words.
- FSM: IDLE -start-> LOAD (address<=base_addr, err/err_count cleared); LOAD -accepted bundle with last=1-> DRAIN; DRAIN -FIFO empty-> DONE; DONE -> IDLE unconditionally (done=1 only in DONE). start outside IDLE is ignored.
- in_ready = (state==LOAD) & FIFO not full. Accept = in_valid & in_ready. No accept is possible in IDLE, DRAIN, or DONE.
- Classes: R={00000}; I={00010,00101,00110,00111,01000}; JI={00001,00011,10101,10110}; JII={00100}; any other opcode is illegal.
- Packing: [31:27]=opcode in every class. R: [26:22]=rd, [21:17]=rs, [16:12]=rt, [11:7]=shamt, [6:2]=aluop, [1:0]=0. I: rd, rs, [16:0]=imm. JI: [26:0]=target. JII: [26:22]=rd, [21:0]=0. Fields unused by the class are forced to zero regardless of their input values.
- Illegal opcode accepted: no FIFO push and no address consumed; err<=1; err_count increments and saturates at all-ones. If last=1 on an illegal bundle, the FSM still moves to DRAIN.
- Latency: a bundle accepted at edge N drives imem_we=1 with its word from cycle N+1 at the earliest (FIFO is registered).
- Output: imem_we = FIFO not empty; imem_data/imem_addr = FIFO head and current address. Pop and address+1 happen when imem_we & imem_ready. Address wraps modulo 2^ADDR_W without error. While imem_ready=0, data and address are held stable.
- Simultaneous push and pop in one cycle is legal, and occupancy is unchanged. Push into a full FIFO cannot occur because in_ready gates it.

Decomposition:
- Shared package: opcode constants (OP_R=00000, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_J, OP_JAL, OP_BEX, OP_SETX, OP_JR); format enum {FMT_R, FMT_I, FMT_JI, FMT_JII, FMT_ILL}; field bit-position constants. The decoder and this block both use these.
- Sub-module: sync_fifo (width 32, depth FIFO_DEPTH, push/pop/full/empty). Classification and packing stay inline.

Test Plan:
- start with base_addr=0x010; bundle R: rd=3, rs=1, rt=2, shamt=0, aluop=0, last=0 -> imem write addr 0x010, data 0x00C22000.
- Next bundle addi: opcode=00101, rd=1, rs=2, imm=5, with rt=31 and target=all-ones as junk -> addr 0x011, data 0x28440005 (junk fields ignored).
- j target=100, then jr rd=31 with last=1 -> writes 0x08000064 @0x012 and 0x27C00000 @0x013; busy drops; done pulses exactly once; FSM returns to IDLE.
- Bundle with opcode=11111 between two legal bundles -> no write for it; err=1; err_count=1; legal words land at consecutive addresses.
- imem_ready=0 for 4 cycles while 3 bundles are offered -> 2 words buffered, in_ready=0, imem_data/addr stable; on release, all 3 words are written in order.
- base_addr=0xFFF with 2 words -> addresses 0xFFF then 0x000. Assert reset_n mid-session -> all outputs at reset values the same cycle, no further writes.
